// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin timeout arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package arb_pkg;

  // flit_id value that marks a header flit.
  localparam int ARB_HEADER_ID = 1;

  // Widest one-hot vector onehot_to_idx can decode.
  localparam int ARB_MAX_PORTS = 32;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Binary index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic int onehot_to_idx(input logic [ARB_MAX_PORTS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < ARB_MAX_PORTS; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first requester after i_ptr, wrapping modulo NPORTS.
// Latency: combinational.
// Backpressure: none; o_pick is all zero when nothing requests.
module rr_priority_pick #(
  parameter int NPORTS = 5,
  parameter int IDX_W  = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NPORTS-1:0] o_pick,
  output logic              o_any
);

  int w_best;
  int w_best_d;
  int w_d;

  // Select the requester with the smallest rotational distance past the pointer.
  always_comb begin
    w_best   = -1;
    w_best_d = NPORTS;
    w_d      = 0;
    o_pick   = '0;
    for (int i = 0; i < NPORTS; i++) begin
      // Distance 0 is port ptr+1, distance NPORTS-1 is the pointer port itself.
      w_d = (i + NPORTS - 1 - int'(i_ptr)) % NPORTS;
      if (i_req[i] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        w_best   = i;
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      o_pick[i] = (i == w_best);
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/rr_timeout_arbiter.sv
// Round-robin output-port arbiter with per-port timeout latched from header flits.
// Latency: 1 cycle req->grant; back-to-back regrant on release with no idle bubble.
// Backpressure: none; a grant is held until its request drops or its period expires.
module rr_timeout_arbiter
  import arb_pkg::*;
#(
  parameter int NPORTS    = 5,
  parameter int LEN_W     = 12,
  parameter int FLIT_ID_W = 3,
  parameter int HEADER_ID = ARB_HEADER_ID,
  localparam int IDX_W    = $clog2(NPORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORTS-1:0]           req,
  input  logic [NPORTS*FLIT_ID_W-1:0] flit_id,
  input  logic [NPORTS*LEN_W-1:0]     length,
  output logic [NPORTS-1:0]           grant,
  output logic                        grant_valid,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        timeout_evt
);

  // Per-port timeout periods and the single hold counter (only one port is granted at a time).
  logic [LEN_W-1:0]  r_period [NPORTS];
  logic [LEN_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_ptr;
  arb_state_t        r_state;
  logic [NPORTS-1:0] r_grant;
  logic              r_grant_valid;
  logic [IDX_W-1:0]  r_grant_idx;
  logic              r_timeout_evt;

  logic [IDX_W-1:0]  w_pick_ptr;
  logic [NPORTS-1:0] w_pick;
  logic              w_any;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_req_g;
  logic [LEN_W-1:0]  w_period_g;
  logic [LEN_W:0]    w_limit;
  logic [LEN_W:0]    w_cnt_inc;
  logic              w_expire;
  logic              w_release;

  // While granted, a re-pick always rotates from the current owner, so the
  // stored pointer is only needed when starting from idle.
  assign w_pick_ptr = (r_state == ARB_GRANT) ? r_grant_idx : r_ptr;

  rr_priority_pick #(
    .NPORTS (NPORTS),
    .IDX_W  (IDX_W)
  ) u_pick (
    .i_req  (req),
    .i_ptr  (w_pick_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  assign w_pick_idx = IDX_W'(onehot_to_idx(ARB_MAX_PORTS'(w_pick)));

  // Is the current owner still requesting.
  assign w_req_g = |(req & r_grant);

  // Period of the current owner (zero when idle).
  always_comb begin
    w_period_g = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (r_grant[i]) w_period_g = w_period_g | r_period[i];
    end
  end

  // A period of 0 behaves as 1; compare one bit wider so cnt+1 never wraps.
  assign w_limit   = (w_period_g == '0) ? {{LEN_W{1'b0}}, 1'b1} : {1'b0, w_period_g};
  assign w_cnt_inc = {1'b0, r_cnt} + {{LEN_W{1'b0}}, 1'b1};
  // A dropped request takes precedence: expiry needs the request still present.
  assign w_expire  = w_req_g && (w_cnt_inc >= w_limit);
  assign w_release = !w_req_g || w_expire;

  // Latch each port's period whenever that port presents a header flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPORTS; i++) r_period[i] <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (flit_id[i*FLIT_ID_W +: FLIT_ID_W] == FLIT_ID_W'(HEADER_ID)) begin
          r_period[i] <= length[i*LEN_W +: LEN_W];
        end
      end
    end
  end

  // Grant FSM: idle -> grant on any request; release on drop or expiry with same-cycle regrant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_ptr         <= IDX_W'(NPORTS - 1);
      r_cnt         <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_timeout_evt <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_timeout_evt <= 1'b0;
          if (w_any) begin
            r_grant       <= w_pick;
            r_grant_idx   <= w_pick_idx;
            r_grant_valid <= 1'b1;
            r_cnt         <= '0;
            r_state       <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (w_release) begin
            r_ptr         <= r_grant_idx;
            r_timeout_evt <= w_expire;
            r_cnt         <= '0;
            if (w_any) begin
              r_grant       <= w_pick;
              r_grant_idx   <= w_pick_idx;
              r_grant_valid <= 1'b1;
            end else begin
              r_grant       <= '0;
              r_grant_valid <= 1'b0;
              r_state       <= ARB_IDLE;
            end
          end else begin
            r_cnt         <= r_cnt + 1'b1;
            r_timeout_evt <= 1'b0;
          end
        end
        default: begin
          r_state       <= ARB_IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_timeout_evt <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign timeout_evt = r_timeout_evt;

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Testbench for rr_timeout_arbiter: vector table, directed corner sequences, randomized model compare.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_rr_timeout_arbiter;

  localparam int N  = 5;
  localparam int LW = 12;
  localparam int FW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*FW-1:0] flit_id;
  logic [N*LW-1:0] length;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [2:0]      grant_idx;
  logic            timeout_evt;

  int n_checks = 0;
  int n_errors = 0;

  rr_timeout_arbiter #(
    .NPORTS    (N),
    .LEN_W     (LW),
    .FLIT_ID_W (FW),
    .HEADER_ID (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flit_id     (flit_id),
    .length      (length),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  hdr;
    logic [LW-1:0] len;
    logic [N-1:0]  e_grant;
    logic [2:0]    e_idx;
    logic          e_valid;
    logic          e_evt;
  } vec_t;

  vec_t tbl [5];

  // Reference model state: owner (-1 idle), rotation pointer, cycles held, periods.
  int m_g, m_ptr, m_held, m_idx;
  bit m_evt;
  int m_per [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [N-1:0] eg, input logic [2:0] ei,
                         input logic ev, input logic et);
    chk({nm, ".grant"}, 32'(grant), 32'(eg));
    chk({nm, ".idx"}, 32'(grant_idx), 32'(ei));
    chk({nm, ".valid"}, 32'(grant_valid), 32'(ev));
    chk({nm, ".evt"}, 32'(timeout_evt), 32'(et));
  endtask

  task automatic set_inputs(input logic [N-1:0] r, input logic [N-1:0] hdr, input logic [LW-1:0] len);
    req     = r;
    flit_id = '0;
    length  = '0;
    for (int i = 0; i < N; i++) begin
      if (hdr[i]) begin
        flit_id[i*FW +: FW] = 3'd1;
        length[i*LW +: LW]  = len;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_inputs('0, '0, '0);
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic int pick_from(input int from, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (from + k) % N;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_g    = -1;
    m_ptr  = N - 1;
    m_held = 0;
    m_idx  = 0;
    m_evt  = 0;
    for (int i = 0; i < N; i++) m_per[i] = 0;
  endtask

  // One clock of the behavioural rules, using periods as they stood before this edge.
  task automatic model_tick(input logic [N-1:0] r);
    int p, lim;
    bit ex;
    m_evt = 0;
    if (m_g < 0) begin
      p = pick_from(m_ptr, r);
      if (p >= 0) begin
        m_g = p; m_idx = p; m_held = 1;
      end
    end else begin
      lim = (m_per[m_g] == 0) ? 1 : m_per[m_g];
      ex  = r[m_g] && (m_held >= lim);
      if (!r[m_g] || ex) begin
        m_ptr = m_g;
        m_evt = ex;
        p = pick_from(m_g, r);
        if (p >= 0) begin
          m_g = p; m_idx = p; m_held = 1;
        end else begin
          m_g = -1;
        end
      end else begin
        m_held++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (flit_id[i*FW +: FW] == 3'd1) m_per[i] = int'(length[i*LW +: LW]);
    end
  endtask

  initial begin
    int e4_idx [8];
    int e4_evt [8];
    logic [N-1:0] eg;

    tbl[0] = '{req: 5'b00110, hdr: 5'b0, len: 12'd0, e_grant: 5'b00010, e_idx: 3'd1, e_valid: 1'b1, e_evt: 1'b0};
    tbl[1] = '{req: 5'b00110, hdr: 5'b0, len: 12'd0, e_grant: 5'b00100, e_idx: 3'd2, e_valid: 1'b1, e_evt: 1'b1};
    tbl[2] = '{req: 5'b00110, hdr: 5'b0, len: 12'd0, e_grant: 5'b00010, e_idx: 3'd1, e_valid: 1'b1, e_evt: 1'b1};
    tbl[3] = '{req: 5'b00110, hdr: 5'b0, len: 12'd0, e_grant: 5'b00100, e_idx: 3'd2, e_valid: 1'b1, e_evt: 1'b1};
    tbl[4] = '{req: 5'b00000, hdr: 5'b0, len: 12'd0, e_grant: 5'b00000, e_idx: 3'd2, e_valid: 1'b0, e_evt: 1'b0};
    e4_idx = '{3, 3, 1, 1, 3, 3, 1, 1};
    e4_evt = '{0, 0, 1, 0, 1, 0, 1, 0};

    // Reset state, then alternating grants with zero periods.
    do_reset();
    chk_out("reset", 5'b0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      set_inputs(tbl[k].req, tbl[k].hdr, tbl[k].len);
      step();
      chk_out($sformatf("alt[%0d]", k), tbl[k].e_grant, tbl[k].e_idx, tbl[k].e_valid, tbl[k].e_evt);
    end

    // Sole requester with period 4: 4-cycle cadence, regrant to itself.
    do_reset();
    set_inputs(5'b00001, 5'b00001, 12'd4);
    step();
    chk_out("solo[0]", 5'b00001, 3'd0, 1'b1, 1'b0);
    set_inputs(5'b00001, 5'b0, 12'd0);
    for (int k = 1; k < 12; k++) begin
      step();
      chk_out($sformatf("solo[%0d]", k), 5'b00001, 3'd0, 1'b1, ((k % 4) == 0));
    end

    // Request drop before expiry hands over without a timeout pulse.
    do_reset();
    set_inputs(5'b00000, 5'b00100, 12'd10);
    step();
    chk_out("drop.idle", 5'b0, 3'd0, 1'b0, 1'b0);
    set_inputs(5'b00100, 5'b0, 12'd0);
    step();
    chk_out("drop.c1", 5'b00100, 3'd2, 1'b1, 1'b0);
    set_inputs(5'b10100, 5'b0, 12'd0);
    step();
    chk_out("drop.c2", 5'b00100, 3'd2, 1'b1, 1'b0);
    step();
    chk_out("drop.c3", 5'b00100, 3'd2, 1'b1, 1'b0);
    set_inputs(5'b10000, 5'b0, 12'd0);
    step();
    chk_out("drop.hand", 5'b10000, 3'd4, 1'b1, 1'b0);
    step();
    chk_out("drop.p4exp", 5'b10000, 3'd4, 1'b1, 1'b1);

    // Ports 1 and 3 with period 2, pointer left at 1: order 3,1,3,1 back to back.
    do_reset();
    set_inputs(5'b00010, 5'b01010, 12'd2);
    step();
    chk_out("rr.setup", 5'b00010, 3'd1, 1'b1, 1'b0);
    set_inputs(5'b00000, 5'b0, 12'd0);
    step();
    chk_out("rr.idle", 5'b0, 3'd1, 1'b0, 1'b0);
    set_inputs(5'b01010, 5'b0, 12'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      eg = N'(1) << e4_idx[k];
      chk_out($sformatf("rr[%0d]", k), eg, 3'(e4_idx[k]), 1'b1, 1'(e4_evt[k]));
    end

    // Header mid-grant shortens the active period.
    do_reset();
    set_inputs(5'b00010, 5'b00010, 12'd8);
    step();
    chk_out("short.c1", 5'b00010, 3'd1, 1'b1, 1'b0);
    set_inputs(5'b00010, 5'b00010, 12'd3);
    step();
    chk_out("short.c2", 5'b00010, 3'd1, 1'b1, 1'b0);
    set_inputs(5'b00010, 5'b0, 12'd0);
    step();
    chk_out("short.c3", 5'b00010, 3'd1, 1'b1, 1'b0);
    step();
    chk_out("short.exp", 5'b00010, 3'd1, 1'b1, 1'b1);

    // Reset mid-grant, then lowest requester wins.
    do_reset();
    set_inputs(5'b10000, 5'b0, 12'd0);
    step();
    chk_out("rst.g4", 5'b10000, 3'd4, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk_out("rst.mid", 5'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    set_inputs(5'b11111, 5'b0, 12'd0);
    step();
    chk_out("rst.first", 5'b00001, 3'd0, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      req = N'($urandom_range(0, (1 << N) - 1) & $urandom_range(0, (1 << N) - 1) | $urandom_range(0, (1 << N) - 1));
      flit_id = '0;
      length  = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) flit_id[i*FW +: FW] = 3'd1;
        else flit_id[i*FW +: FW] = 3'($urandom_range(2, 7));
        length[i*LW +: LW] = LW'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        model_tick(req);
      end
      step();
      rst = 1'b0;
      eg = (m_g < 0) ? '0 : (N'(1) << m_g);
      chk_out($sformatf("rnd[%0d]", c), eg, 3'(m_idx), (m_g >= 0), m_evt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
